// File: rtl/qpsk_tx_pkg.sv
// Shared QPSK transmit definitions: feeder FSM states, the Gray-coded
// differential dibit-to-phase-delta map and the preamble phase step.
// Also intended for use by the demodulator side.
package qpsk_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA
    } tx_state_t;

    // Preamble alternates the carrier by 180 degrees each symbol.
    localparam logic [1:0] PREAMBLE_DELTA = 2'd2;

    // Gray map: 00 -> +0, 01 -> +1, 11 -> +2, 10 -> +3 (quarter turns).
    function automatic logic [1:0] dibit_to_delta(input logic [1:0] dibit);
        logic [1:0] delta;
        unique case (dibit)
            2'b00:   delta = 2'd0;
            2'b01:   delta = 2'd1;
            2'b11:   delta = 2'd2;
            default: delta = 2'd3;
        endcase
        return delta;
    endfunction

endpackage

// File: rtl/qpsk_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO, depth 2**AW.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (flushes contents)
//   wr_en       - push wr_data (ignored when full)
//   wr_data     - byte to push
//   rd_en       - pop head (ignored when empty)
//   rd_data     - current head byte, valid whenever empty=0
//   empty, full - occupancy flags derived from the registered level
//   level       - number of bytes held
module qpsk_byte_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    // Flags come from the registered level only, so a write in the same
    // cycle is never visible to a read on an empty FIFO.
    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/qpsk_symbol_feeder.sv
// QPSK symbol feeder: buffers payload bytes, sends a fixed 180-degree
// alternating preamble, then splits bytes into dibits (MSB first) and
// differentially encodes them into a 2-bit carrier phase index.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   s_data       - payload byte; s_valid qualifies it, s_ready accepts it
//   next_output  - one-cycle symbol strobe from timing control
//   qpsk_go      - transmit enable from timing control
//   phase        - differential carrier phase index (0..3 quarter turns)
//   sym_valid    - one-cycle pulse when phase is updated
//   tx_active    - high while in PREAMBLE or DATA
//   underrun     - one-cycle pulse when a DATA strobe found no data
//   fifo_level   - bytes held in the input FIFO
module qpsk_symbol_feeder
    import qpsk_tx_pkg::*;
#(
    parameter int unsigned FIFO_AW       = 4,
    parameter int unsigned PREAMBLE_SYMS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             next_output,
    input  logic             qpsk_go,
    output logic [1:0]       phase,
    output logic             sym_valid,
    output logic             tx_active,
    output logic             underrun,
    output logic [FIFO_AW:0] fifo_level
);

    tx_state_t  state, state_n;
    logic [7:0] pre_cnt, pre_cnt_n;
    logic [5:0] shreg, shreg_n;     // remaining dibits, next one in [5:4]
    logic [1:0] cnt, cnt_n;         // dibits left in shreg
    logic [1:0] phase_n;
    logic       sym_valid_n;
    logic       underrun_n;
    logic       pop;
    logic [7:0] head;
    logic       fifo_empty;
    logic       fifo_full;

    assign s_ready   = !reset && !fifo_full;
    assign tx_active = (state != IDLE);

    qpsk_byte_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (s_valid && s_ready),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            shreg     <= '0;
            cnt       <= '0;
            phase     <= '0;
            sym_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_n;
            pre_cnt   <= pre_cnt_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            phase     <= phase_n;
            sym_valid <= sym_valid_n;
            underrun  <= underrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        pre_cnt_n   = pre_cnt;
        shreg_n     = shreg;
        cnt_n       = cnt;
        phase_n     = phase;
        sym_valid_n = 1'b0;
        underrun_n  = 1'b0;
        pop         = 1'b0;

        unique case (state)
            IDLE: begin
                // A strobe coinciding with qpsk_go is deliberately ignored.
                if (qpsk_go) begin
                    state_n   = PREAMBLE;
                    pre_cnt_n = 8'(PREAMBLE_SYMS);
                end
            end

            PREAMBLE: begin
                if (next_output) begin
                    if (!qpsk_go) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        phase_n     = phase + PREAMBLE_DELTA;
                        pre_cnt_n   = pre_cnt - 8'd1;
                        sym_valid_n = 1'b1;
                        if (pre_cnt == 8'd1) begin
                            state_n = DATA;
                        end
                    end
                end
            end

            DATA: begin
                if (next_output) begin
                    if (!qpsk_go) begin
                        // Stop on a symbol boundary; partial byte is dropped.
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt != '0) begin
                        phase_n     = phase + dibit_to_delta(shreg[5:4]);
                        shreg_n     = {shreg[3:0], 2'b00};
                        cnt_n       = cnt - 2'd1;
                        sym_valid_n = 1'b1;
                    end else if (!fifo_empty) begin
                        pop         = 1'b1;
                        phase_n     = phase + dibit_to_delta(head[7:6]);
                        shreg_n     = head[5:0];
                        cnt_n       = 2'd3;
                        sym_valid_n = 1'b1;
                    end else begin
                        underrun_n  = 1'b1;
                        sym_valid_n = 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qpsk_symbol_feeder.sv
module tb_qpsk_symbol_feeder;

    localparam int PRE   = 16;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       next_output = 1'b0;
    logic       qpsk_go = 1'b0;
    logic       s_ready;
    logic [1:0] phase;
    logic       sym_valid;
    logic       tx_active;
    logic       underrun;
    logic [4:0] fifo_level;

    qpsk_symbol_feeder #(
        .FIFO_AW       (4),
        .PREAMBLE_SYMS (PRE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .next_output (next_output),
        .qpsk_go     (qpsk_go),
        .phase       (phase),
        .sym_valid   (sym_valid),
        .tx_active   (tx_active),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte queue, dibit queue, preamble countdown.
    logic [7:0] mq[$];
    int         dq[$];
    int         delta_of[4] = '{0, 1, 3, 2};
    bit         m_active = 1'b0;
    int         m_pre = 0;
    int         m_phase = 0;
    bit         m_sv = 1'b0;
    bit         m_ur = 1'b0;
    int         m_osz;
    bit         m_push;
    int         m_b;
    int         m_d;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            dq.delete();
            m_active = 1'b0;
            m_pre    = 0;
            m_phase  = 0;
            m_sv     = 1'b0;
            m_ur     = 1'b0;
        end else begin
            m_osz  = mq.size();
            m_push = s_valid && (m_osz < DEPTH);
            m_sv   = 1'b0;
            m_ur   = 1'b0;
            if (!m_active) begin
                if (qpsk_go) begin
                    m_active = 1'b1;
                    m_pre    = PRE;
                end
            end else if (next_output) begin
                if (!qpsk_go) begin
                    m_active = 1'b0;
                    dq.delete();
                end else if (m_pre > 0) begin
                    m_phase = (m_phase + 2) % 4;
                    m_pre--;
                    m_sv = 1'b1;
                end else begin
                    if (dq.size() == 0 && m_osz > 0) begin
                        m_b = int'(mq.pop_front());
                        for (int k = 3; k >= 0; k--) dq.push_back((m_b >> (2 * k)) & 3);
                    end
                    if (dq.size() > 0) begin
                        m_d = dq.pop_front();
                        m_phase = (m_phase + delta_of[m_d]) % 4;
                    end else begin
                        m_ur = 1'b1;
                    end
                    m_sv = 1'b1;
                end
            end
            if (m_push) mq.push_back(s_data);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            cmp("phase", int'(phase), m_phase);
            cmp("sym_valid", int'(sym_valid), int'(m_sv));
            cmp("underrun", int'(underrun), int'(m_ur));
            cmp("tx_active", int'(tx_active), int'(m_active));
            cmp("fifo_level", int'(fifo_level), mq.size());
            cmp("s_ready", int'(s_ready), int'(!reset && mq.size() < DEPTH));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        next_output = 1'b1;
        tick();
        next_output = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic run_preamble();
        qpsk_go = 1'b1;
        tick();
        for (int i = 0; i < PRE; i++) begin
            strobe();
            cmp("pre_phase", int'(phase), (i % 2 == 0) ? 2 : 0);
            cmp("pre_sv", int'(sym_valid), 1);
            tick();
            cmp("pre_sv_drop", int'(sym_valid), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int exp2[4] = '{0, 1, 0, 2};
    int p_save;

    initial begin
        // Reset values
        reset = 1'b1;
        tick();
        tick();
        check_en = 1'b1;
        cmp("rst_phase", int'(phase), 0);
        cmp("rst_level", int'(fifo_level), 0);
        cmp("rst_tx_active", int'(tx_active), 0);
        cmp("rst_s_ready", int'(s_ready), 0);
        reset = 1'b0;
        #1;
        cmp("rel_s_ready", int'(s_ready), 1);
        tick();

        // Preamble
        run_preamble();
        cmp("pre_tx_active", int'(tx_active), 1);

        // One byte 0x1B through DATA
        push(8'h1B);
        cmp("push_level", int'(fifo_level), 1);
        for (int i = 0; i < 4; i++) begin
            strobe();
            cmp("data_phase", int'(phase), exp2[i]);
            if (i == 0) cmp("pop_level", int'(fifo_level), 0);
            tick();
        end

        // Underrun, then push racing a strobe on empty FIFO
        strobe();
        cmp("ur_pulse", int'(underrun), 1);
        cmp("ur_phase", int'(phase), 2);
        cmp("ur_sv", int'(sym_valid), 1);
        tick();
        cmp("ur_drop", int'(underrun), 0);
        s_valid = 1'b1;
        s_data  = 8'hC0;
        strobe();
        s_valid = 1'b0;
        cmp("race_ur", int'(underrun), 1);
        cmp("race_level", int'(fifo_level), 1);
        tick();
        strobe();
        cmp("race_consume_ur", int'(underrun), 0);
        cmp("race_consume_phase", int'(phase), 0);
        cmp("race_consume_level", int'(fifo_level), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            strobe();
        end
        tick();

        // Fill to full and beyond
        s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_data = 8'(i);
            tick();
        end
        cmp("full_level", int'(fifo_level), 16);
        cmp("full_ready", int'(s_ready), 0);
        s_data = 8'hAA;
        tick();
        cmp("full_hold_level", int'(fifo_level), 16);
        strobe();
        cmp("full_pop_level", int'(fifo_level), 15);
        cmp("full_pop_ready", int'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        cmp("full_17th_level", int'(fifo_level), 16);

        // Abort mid-byte, restart preamble
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        run_preamble();
        push(8'hFF);
        strobe();
        tick();
        strobe();
        tick();
        p_save = int'(phase);
        qpsk_go = 1'b0;
        tick();
        cmp("go_low_no_strobe_active", int'(tx_active), 1);
        strobe();
        cmp("abort_sv", int'(sym_valid), 0);
        cmp("abort_tx_active", int'(tx_active), 0);
        cmp("abort_phase", int'(phase), p_save);
        tick();
        run_preamble();
        strobe();
        cmp("restart_discard_ur", int'(underrun), 1);
        tick();

        // Reset during DATA with five bytes held
        push(8'h40);
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        strobe();
        cmp("pre_reset_level", int'(fifo_level), 5);
        reset = 1'b1;
        tick();
        cmp("mid_rst_phase", int'(phase), 0);
        cmp("mid_rst_level", int'(fifo_level), 0);
        cmp("mid_rst_tx_active", int'(tx_active), 0);
        cmp("mid_rst_ready", int'(s_ready), 0);
        reset = 1'b0;
        #1;
        cmp("mid_rst_rel_ready", int'(s_ready), 1);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 599) == 0);
            qpsk_go     = ($urandom_range(0, 149) != 0);
            next_output = ($urandom_range(0, 3) == 0);
            s_valid     = ($urandom_range(0, 9) < (2 + 2 * (i / 1000)));
            s_data      = 8'($urandom);
            tick();
        end
        reset = 1'b0;
        s_valid = 1'b0;
        next_output = 1'b0;
        tick();
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
